pc_fetch: RTL and testbench



---
 rtl/pc_fetch.sv | 119 +++++++++++
 tb/tb_pc_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch sequencer: IDLE -> FETCH (req/ack) -> EXEC (wait retire) -> next PC.
// Optional macro PC_FETCH_MISALIGN_TRAP_EN: misaligned targets halt the core until trap_clr instead of being truncated.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Cnd,
    input  logic        JumpReg,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic        retire,
    input  logic        trap_clr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] jump_base;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    // jalr adds to rs1 and drops bit 0; branches/jal add to the current pc
    always_comb begin
        jump_base   = JumpReg ? rs1_data : pc;
        jump_target = jump_base + imm;
        if (JumpReg) begin
            jump_target[0] = 1'b0;
        end
        next_pc = Cnd ? jump_target : pc_plus4;
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic next_misaligned;
    assign next_misaligned = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (state == EXEC && retire && next_misaligned) begin
            misalign <= 1'b1;
        end else if (state == HALT && trap_clr) begin
            misalign <= 1'b0;
        end
    end
`else
    logic next_misaligned;
    assign next_misaligned = 1'b0;
    assign misalign        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= 32'd0;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        inst_valid <= 1'b0;
                        if (next_misaligned) begin
                            // pc keeps the faulting instruction's address
                            state <= HALT;
                        end else begin
                            pc       <= next_pc & ~32'h3;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                HALT: begin
                    if (trap_clr) begin
                        pc       <= RESET_PC;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state      <= IDLE;
                    inst_valid <= 1'b0;
                    imem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with RESET_PC = 32'h100; inputs change on the falling edge, outputs sampled there too.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        Cnd;
    logic        JumpReg;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        retire;
    logic        trap_clr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_fetch #(.RESET_PC(32'h100)) dut (
        .clk        (clk),
        .rst        (rst),
        .Cnd        (Cnd),
        .JumpReg    (JumpReg),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .retire     (retire),
        .trap_clr   (trap_clr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misalign   (misalign)
    );

    // one-cycle ack pulse while in FETCH
    task automatic do_ack(input logic [31:0] data);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    // one-cycle retire pulse while in EXEC
    task automatic do_retire(input logic c, input logic jr, input logic [31:0] im, input logic [31:0] rs1);
        Cnd      = c;
        JumpReg  = jr;
        imm      = im;
        rs1_data = rs1;
        retire   = 1'b1;
        @(negedge clk);
        retire   = 1'b0;
        Cnd      = 1'b0;
        JumpReg  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; Cnd = 0; JumpReg = 0; imm = 0; rs1_data = 0;
        retire = 0; trap_clr = 0; imem_ack = 0; imem_rdata = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({imem_req, inst_valid, misalign} !== 3'b000) begin
            fails++; $display("FAIL reset_ctl: got %b want 000", {imem_req, inst_valid, misalign});
        end
        tests++;
        if (pc !== 32'h100 || pc_plus4 !== 32'h104 || inst !== 32'h0) begin
            fails++; $display("FAIL reset_val: pc=%h p4=%h inst=%h want 100/104/0", pc, pc_plus4, inst);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            fails++; $display("FAIL first_req: req=%b addr=%h want 1/100", imem_req, imem_addr);
        end
    endtask

    task automatic test_fetch;
        do_ack(32'h0000_0013);
        tests++;
        if (inst_valid !== 1'b1 || inst !== 32'h13 || imem_req !== 1'b0) begin
            fails++; $display("FAIL fetch: v=%b inst=%h req=%b want 1/13/0", inst_valid, inst, imem_req);
        end
        // stray ack in EXEC must not overwrite inst
        do_ack(32'hDEAD_BEEF);
        tests++;
        if (inst !== 32'h13 || inst_valid !== 1'b1) begin
            fails++; $display("FAIL exec_ack_ignored: inst=%h v=%b want 13/1", inst, inst_valid);
        end
    endtask

    task automatic test_fetch_stall;
        do_retire(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            retire = (i == 1);
            Cnd    = (i == 1);
            imm    = 32'h40;
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h104 || inst_valid !== 1'b0) begin
                fails++; $display("FAIL stall%0d: req=%b addr=%h v=%b want 1/104/0", i, imem_req, imem_addr, inst_valid);
            end
        end
        retire = 1'b0; Cnd = 1'b0;
        do_ack(32'h0000_0093);
        tests++;
        if (inst !== 32'h93 || inst_valid !== 1'b1) begin
            fails++; $display("FAIL stall_ack: inst=%h v=%b want 93/1", inst, inst_valid);
        end
    endtask

    task automatic test_branch;
        do_retire(1'b1, 1'b0, 32'h0000_00FC, 32'h0);
        tests++;
        if (pc !== 32'h200 || imem_req !== 1'b1) begin
            fails++; $display("FAIL jal_fwd: pc=%h req=%b want 200/1", pc, imem_req);
        end
        do_ack(32'h13);
        do_retire(1'b0, 1'b1, 32'h1234, 32'h5555);
        tests++;
        if (pc !== 32'h204) begin
            fails++; $display("FAIL seq: pc=%h want 204", pc);
        end
        do_ack(32'h13);
        do_retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
        do_ack(32'h13);
        do_retire(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        tests++;
        if (pc !== 32'h1F8) begin
            fails++; $display("FAIL branch_back: pc=%h want 1f8", pc);
        end
        do_ack(32'h13);
        do_retire(1'b1, 1'b1, 32'h4, 32'h1001);
        tests++;
        if (pc !== 32'h1004 || pc_plus4 !== 32'h1008) begin
            fails++; $display("FAIL jalr: pc=%h p4=%h want 1004/1008", pc, pc_plus4);
        end
    endtask

    task automatic test_wrap;
        do_ack(32'h13);
        do_retire(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);
        tests++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            fails++; $display("FAIL wrap_setup: pc=%h p4=%h want fffffffc/0", pc, pc_plus4);
        end
        do_ack(32'h13);
        do_retire(1'b0, 1'b0, 32'h0, 32'h0);
        tests++;
        if (pc !== 32'h0 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL wrap: pc=%h addr=%h want 0/0", pc, imem_addr);
        end
    endtask

    task automatic test_back_to_back;
        imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
        @(negedge clk);
        imem_ack = 1'b0;
        retire = 1'b1; Cnd = 1'b0;
        @(negedge clk);
        retire = 1'b0;
        tests++;
        if (pc !== 32'h4 || imem_req !== 1'b1 || inst !== 32'h33) begin
            fails++; $display("FAIL b2b: pc=%h req=%b inst=%h want 4/1/33", pc, imem_req, inst);
        end
    endtask

    task automatic test_misalign;
        do_ack(32'h13);
        do_retire(1'b1, 1'b1, 32'h0, 32'h200);
        do_ack(32'h13);
        do_retire(1'b1, 1'b0, 32'h6, 32'h0);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        tests++;
        if (pc !== 32'h200 || misalign !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            fails++; $display("FAIL halt: pc=%h mis=%b req=%b v=%b want 200/1/0/0", pc, misalign, imem_req, inst_valid);
        end
        do_retire(1'b0, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++;
        if (pc !== 32'h200 || misalign !== 1'b1 || imem_req !== 1'b0) begin
            fails++; $display("FAIL halt_hold: pc=%h mis=%b req=%b want 200/1/0", pc, misalign, imem_req);
        end
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        tests++;
        if (pc !== 32'h100 || misalign !== 1'b0 || imem_req !== 1'b1) begin
            fails++; $display("FAIL trap_clr: pc=%h mis=%b req=%b want 100/0/1", pc, misalign, imem_req);
        end
`else
        tests++;
        if (pc !== 32'h204 || misalign !== 1'b0 || imem_req !== 1'b1) begin
            fails++; $display("FAIL trunc: pc=%h mis=%b req=%b want 204/0/1", pc, misalign, imem_req);
        end
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        tests++;
        if (pc !== 32'h204 || imem_req !== 1'b1 || misalign !== 1'b0) begin
            fails++; $display("FAIL trap_clr_ignored: pc=%h req=%b mis=%b want 204/1/0", pc, imem_req, misalign);
        end
`endif
    endtask

    task automatic test_reset_mid_fetch;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h100) begin
            fails++; $display("FAIL async_rst: req=%b v=%b pc=%h want 0/0/100", imem_req, inst_valid, pc);
        end
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++;
        if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h100 || inst !== 32'h0) begin
            fails++; $display("FAIL late_ack: req=%b v=%b addr=%h inst=%h want 1/0/100/0",
                              imem_req, inst_valid, imem_addr, inst);
        end
        do_ack(32'h0000_0073);
        tests++;
        if (inst !== 32'h73 || inst_valid !== 1'b1) begin
            fails++; $display("FAIL refetch: inst=%h v=%b want 73/1", inst, inst_valid);
        end
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_fetch_stall;
        test_branch;
        test_wrap;
        test_back_to_back;
        test_misalign;
        test_reset_mid_fetch;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
